// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues PC-addressed fetches to instruction memory, tracks in-flight
// requests and buffers returned words in an in-order FIFO toward decode.
module instr_fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        ifu_clk,
    input  logic        ifu_rst,
    input  logic [31:0] PC_CNT,
    output logic        pc_write,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_fifo_cnt;
    logic [31:0]   r_pcq [DEPTH];
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [PW-1:0] r_fifo_wr;
    logic [PW-1:0] r_fifo_rd;

    logic          w_pop;
    logic [CW:0]   w_occ;
    logic [CW:0]   w_credit;
    logic          w_accept;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // A redirect kills the pop; credit counts every slot an in-flight request may land in.
    assign w_pop    = dec_valid & dec_ready & ~flush;
    assign w_occ    = {1'b0, r_out_cnt} + {1'b0, r_fifo_cnt};
    assign w_credit = (CW+1)'(DEPTH) - w_occ + (CW+1)'(w_pop);
    assign imem_req  = ~ifu_rst & ~flush & (w_credit != '0);
    assign imem_addr = PC_CNT;
    assign w_accept  = imem_req & imem_gnt;
    assign pc_write  = ~ifu_rst & (w_accept | flush);

    // Responses with nothing outstanding are ignored; stale ones are dropped.
    assign w_resp = imem_rvalid & (r_out_cnt != '0);
    assign w_drop = w_resp & ((r_drop_cnt != '0) | flush);
    assign w_push = w_resp & ~w_drop;

    assign dec_valid = (r_fifo_cnt != '0);
    assign dec_pc    = r_fifo_pc[r_fifo_rd];
    assign dec_instr = r_fifo_instr[r_fifo_rd];

    // In-flight request tracking: outstanding count, PC queue and drop count.
    always_ff @(posedge ifu_clk) begin
        if (ifu_rst) begin
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pcq[i] <= 32'h0000_0000;
            end
        end else begin
            r_out_cnt <= r_out_cnt + CW'(w_accept) - CW'(w_resp);
            if (w_accept) begin
                r_pcq[r_pcq_wr] <= PC_CNT;
                r_pcq_wr        <= ptr_inc(r_pcq_wr);
            end
            if (w_resp) begin
                r_pcq_rd <= ptr_inc(r_pcq_rd);
            end
            if (flush) begin
                r_drop_cnt <= r_out_cnt - CW'(w_resp);
            end else if (w_resp && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    // Decode FIFO; a flush empties it and overrides any pop.
    always_ff @(posedge ifu_clk) begin
        if (ifu_rst) begin
            r_fifo_cnt <= '0;
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]    <= 32'h0000_0000;
                r_fifo_instr[i] <= 32'h0000_0000;
            end
        end else if (flush) begin
            r_fifo_cnt <= '0;
            r_fifo_rd  <= r_fifo_wr;
        end else begin
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_fifo_pc[r_fifo_wr]    <= r_pcq[r_pcq_rd];
                r_fifo_instr[r_fifo_wr] <= imem_rdata;
                r_fifo_wr               <= ptr_inc(r_fifo_wr);
            end
            if (w_pop) begin
                r_fifo_rd <= ptr_inc(r_fifo_rd);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: an in-order memory model plus a queue-level
// reference of which fetched PCs must reach decode.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        ifu_clk = 1'b0;
    logic        ifu_rst;
    logic [31:0] PC_CNT;
    logic        pc_write;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    always #5 ifu_clk = ~ifu_clk;

    instr_fetch_unit #(.DEPTH(DEPTH)) dut (
        .ifu_clk     (ifu_clk),
        .ifu_rst     (ifu_rst),
        .PC_CNT      (PC_CNT),
        .pc_write    (pc_write),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mq[$];     // requests accepted by memory, not yet answered
    logic [31:0] fq[$];     // PCs whose instructions are owed to decode, in order
    logic [31:0] pc_reg;
    int          cyc;
    int          pops;
    int          spur_pct;
    int          n_checks;
    int          n_fail;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ifu_clk);
            ifu_rst     = 1'b1;
            PC_CNT      = 32'h0;
            flush       = 1'b0;
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            dec_ready   = 1'b1;
            #1;
            chk_val("rst_imem_req", imem_req, 1'b0);
            chk_val("rst_pc_write", pc_write, 1'b0);
            if (i > 0) begin
                chk_val("rst_dec_valid", dec_valid, 1'b0);
                chk_val("rst_dec_instr", dec_instr, 32'h0);
                chk_val("rst_dec_pc", dec_pc, 32'h0);
            end
        end
        mq.delete();
        fq.delete();
        pc_reg = 32'h0;
        pops   = 0;
    endtask

    // flush_mode: 0 none, 1 always, 2 exactly when a real response arrives, 3 random.
    task automatic step(input int gnt_pct, input int rdy_pct, input int flush_mode,
                        input logic [31:0] tgt, input int k_lo, input int k_hi);
        bit    real_rv;
        bit    exp_pop;
        bit    exp_req;
        bit    dut_acc;
        mreq_t e;
        @(negedge ifu_clk);
        ifu_rst   = 1'b0;
        PC_CNT    = pc_reg;
        imem_gnt  = ($urandom_range(99) < gnt_pct);
        dec_ready = ($urandom_range(99) < rdy_pct);
        real_rv   = (mq.size() > 0) && (mq[0].due <= cyc);
        if (real_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = (mq.size() == 0) && ($urandom_range(99) < spur_pct);
            imem_rdata  = $urandom;
        end
        case (flush_mode)
            1:       flush = 1'b1;
            2:       flush = real_rv;
            3:       flush = ($urandom_range(99) < 5);
            default: flush = 1'b0;
        endcase
        #1;
        exp_pop = (fq.size() > 0) && dec_ready && !flush;
        exp_req = !flush && ((DEPTH - (mq.size() + fq.size()) + int'(exp_pop)) > 0);
        chk_val("imem_req", imem_req, exp_req);
        chk_val("pc_write", pc_write, (exp_req && imem_gnt) || flush);
        chk_val("imem_addr", imem_addr, PC_CNT);
        chk_val("dec_valid", dec_valid, fq.size() > 0);
        if (fq.size() > 0) begin
            chk_val("dec_pc", dec_pc, fq[0]);
            chk_val("dec_instr", dec_instr, mem_word(fq[0]));
        end
        dut_acc = imem_req && imem_gnt;
        if (exp_pop) begin
            void'(fq.pop_front());
            pops++;
        end
        if (real_rv) begin
            e = mq.pop_front();
            if (!e.stale && !flush) begin
                fq.push_back(e.addr);
            end
        end
        if (flush) begin
            fq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
        end
        if (dut_acc) begin
            mq.push_back('{addr: PC_CNT, due: cyc + $urandom_range(k_hi, k_lo), stale: 1'b0});
            chk_val("occupancy_le_depth", (mq.size() + fq.size()) <= DEPTH, 1'b1);
        end
        if (flush) begin
            pc_reg = tgt;
        end else if (exp_req && imem_gnt) begin
            pc_reg = pc_reg + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        spur_pct = 0;
        ifu_rst  = 1'b1;
        do_reset(2);

        // Back-to-back streaming with a single-cycle memory.
        for (int i = 0; i < 12; i++) step(100, 100, 0, 32'h0, 1, 1);
        chk_val("stream_pops", pops, 10);

        // Decode backpressure fills the budget, then drains in order.
        for (int i = 0; i < 6; i++) step(100, 0, 0, 32'h0, 1, 1);
        for (int i = 0; i < 6; i++) step(100, 100, 0, 32'h0, 1, 1);

        // Grant stall at 0x20.
        step(100, 100, 1, 32'h20, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 100, 0, 32'h0, 1, 1);
        for (int i = 0; i < 4; i++) step(100, 100, 0, 32'h0, 1, 1);

        // Flush to 0x100 while responses are outstanding on a slow memory.
        for (int i = 0; i < 4; i++) step(100, 0, 0, 32'h0, 3, 3);
        step(100, 0, 1, 32'h100, 3, 3);
        for (int i = 0; i < 10; i++) step(100, 100, 0, 32'h0, 1, 1);

        // Flush landing on the same cycle as a response, with decode ready.
        for (int i = 0; i < 4; i++) step(100, 100, 0, 32'h0, 2, 2);
        step(100, 100, 2, 32'h200, 2, 2);
        for (int i = 0; i < 8; i++) step(100, 100, 0, 32'h0, 2, 2);

        // Random traffic, a mid-run reset, then more random traffic.
        spur_pct = 10;
        for (int i = 0; i < 400; i++) step(70, 70, 3, {$urandom_range(4095), 2'b00}, 1, 3);
        do_reset(2);
        for (int i = 0; i < 150; i++) step(70, 70, 3, {$urandom_range(4095), 2'b00}, 1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
